mux10_rr_arbiter: RTL

- Round-robin arbiter that shares one 10-way mux10 datapath among 10 requesters (e.g. issue-slot result sources competing for a shared writeback/bypass bus).
- Produces the registered 4-bit select for the mux10, a one-hot grant, and a valid flag.
- Supports multi-cycle ownership, ended by the owner or by a hold-limit preemption.
- Sits directly in front of mux10; its select output never exceeds 9.

---
 rtl/mux10_arb_pkg.sv | 8 +
 rtl/rr_pick10.sv | 33 +++
 rtl/mux10_rr_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mux10_arb_pkg.sv
// Shared types and sizes for the mux10 round-robin arbiter.
package mux10_arb_pkg;
  localparam int NREQ  = 10;
  localparam int SEL_W = 4;

  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_pick10.sv
// Combinational circular priority pick over 10 candidates starting at ptr.
// Zero latency; the caller masks candidates and must keep ptr in 0..9.
module rr_pick10
  import mux10_arb_pkg::*;
(
  input  logic [NREQ-1:0] cand,
  input  sel_t            ptr,
  output sel_t            idx,
  output logic            found
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  sel_t              off;
  logic [SEL_W:0]    sum;

  always_comb begin
    dbl   = {cand, cand} >> ptr;
    rot   = dbl[NREQ-1:0];
    off   = '0;
    found = 1'b0;
    // Walk downwards so the lowest set offset from ptr wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = SEL_W'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= (SEL_W+1)'(NREQ)) ? SEL_W'(sum - (SEL_W+1)'(NREQ)) : sum[SEL_W-1:0];
  end

endmodule

// File: rtl/mux10_rr_arbiter.sv
// Round-robin owner select for a shared mux10; grant registered 1 cycle after req,
// ownership ends on owner last, owner drop, or MAX_HOLD preemption with bubble-free handoff.
module mux10_rr_arbiter
  import mux10_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  output logic [SEL_W-1:0] sel,
  output logic            sel_valid,
  output logic [NREQ-1:0] gnt,
  output logic            busy
);

  arb_state_t      state_q, state_d;
  sel_t            sel_q, sel_d;
  sel_t            ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            vld_q, vld_d;
  logic [7:0]      hold_q, hold_d;

  logic [NREQ-1:0] owner_bit, cand;
  sel_t            nxt_ptr, pick_ptr, pick_idx;
  logic            pick_found, own_req, own_last, hold_end, grant_end;

  assign owner_bit = NREQ'(1) << sel_q;
  assign own_req   = |(req & owner_bit);
  assign own_last  = |(last & owner_bit);
  assign nxt_ptr   = (sel_q == SEL_W'(NREQ - 1)) ? '0 : sel_q + SEL_W'(1);
  assign hold_end  = (hold_q == 8'(MAX_HOLD - 1));
  assign grant_end = (own_req && own_last) || !own_req || hold_end;

  // While granted, the re-pick starts past the owner and excludes it.
  assign pick_ptr = (state_q == GRANT) ? nxt_ptr : ptr_q;
  assign cand     = (state_q == GRANT) ? (req & ~owner_bit) : req;

  rr_pick10 u_pick (
    .cand  (cand),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          vld_d   = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (grant_end) begin
          ptr_d = nxt_ptr;
          if (pick_found) begin
            sel_d  = pick_idx;
            gnt_d  = NREQ'(1) << pick_idx;
            hold_d = '0;
          end else if (hold_end && own_req) begin
            hold_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            vld_d   = 1'b0;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      hold_q  <= hold_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = vld_q;
  assign gnt       = gnt_q;
  assign busy      = vld_q;

  a_sel_range: assert property (@(posedge clk) disable iff (!resetn) sel_q <= SEL_W'(NREQ - 1));
  a_gnt_oh:    assert property (@(posedge clk) disable iff (!resetn) $onehot0(gnt_q));

endmodule
